// File: rtl/mem_burst_ctrl.sv
// ----------------------------------------------------------------------------
// mem_burst_ctrl
//    Burst load/store controller and sole master of the data RAM. Accepts
//    single or burst requests over a valid/ready handshake, drives the RAM
//    write and read ports with incrementing (wrapping) addresses, and returns
//    load data through a 2-entry output buffer with backpressure.
//
// Ports
//    clk, rst                  clock, asynchronous active-low reset
//    req_valid/req_ready       request handshake
//    req_write, req_addr       burst direction and first beat address
//    req_len                   beats minus one
//    wr_data/wr_valid/wr_ready store beat stream
//    rd_data/rd_valid/rd_last  load beat stream (buffer head), rd_ready pops
//    busy                      burst in progress
//    write_en/write_adress/data_in   RAM write port
//    rd_en/rd_adress                 RAM read port
//    data_out                  RAM read data, valid one cycle after rd_en
// ----------------------------------------------------------------------------
module mem_burst_ctrl #(
   parameter int addr_size = 8,
   parameter int data_size = 8,
   parameter int len_size  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [addr_size-1:0] req_addr,
   input  logic [len_size-1:0]  req_len,
   input  logic [data_size-1:0] wr_data,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   output logic [data_size-1:0] rd_data,
   output logic                 rd_valid,
   output logic                 rd_last,
   input  logic                 rd_ready,
   output logic                 busy,
   output logic                 write_en,
   output logic [addr_size-1:0] write_adress,
   output logic [data_size-1:0] data_in,
   output logic                 rd_en,
   output logic [addr_size-1:0] rd_adress,
   input  logic [data_size-1:0] data_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [addr_size-1:0]  addr_q, addr_d;
   logic [len_size-1:0]   len_q, len_d;
   // Beats accepted (store) or issued (load); one bit wider than req_len so
   // an all-ones length still counts up to the full 2^len_size beats.
   logic [len_size:0]     cnt_q, cnt_d;
   logic [len_size:0]     ret_q, ret_d;
   logic                  inflight_q, inflight_d;

   logic [data_size-1:0]  fifo_data_q [2];
   logic [data_size-1:0]  fifo_data_d [2];
   logic                  fifo_last_q [2];
   logic                  fifo_last_d [2];
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [1:0]            count_q, count_d;

   logic [len_size:0]     beats;
   logic                  push;
   logic                  pop;
   logic [2:0]            occ;

   assign beats = {1'b0, len_q} + (len_size+1)'(1);
   // A read issued last cycle returns now and always lands in the buffer.
   assign push  = inflight_q;
   assign pop   = (count_q != 2'd0) && rd_ready;
   // Slots already claimed once this cycle's pop is taken into account.
   assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

   assign rd_valid = (count_q != 2'd0);
   assign rd_data  = fifo_data_q[rd_ptr_q];
   assign rd_last  = fifo_last_q[rd_ptr_q];
   assign busy     = (state_q != IDLE);

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      ret_d        = ret_q;
      inflight_d   = 1'b0;
      fifo_data_d  = fifo_data_q;
      fifo_last_d  = fifo_last_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q + {1'b0, push} - {1'b0, pop};
      req_ready    = 1'b0;
      wr_ready     = 1'b0;
      write_en     = 1'b0;
      write_adress = '0;
      data_in      = '0;
      rd_en        = 1'b0;
      rd_adress    = '0;

      if (push) begin
         fifo_data_d[wr_ptr_q] = data_out;
         fifo_last_d[wr_ptr_q] = (ret_q == {1'b0, len_q});
         wr_ptr_d              = ~wr_ptr_q;
         ret_d                 = ret_q + (len_size+1)'(1);
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_d  = req_addr;
               len_d   = req_len;
               cnt_d   = '0;
               ret_d   = '0;
               state_d = req_write ? WRITE : READ;
            end
         end
         WRITE: begin
            wr_ready     = 1'b1;
            write_en     = wr_valid;
            write_adress = addr_q;
            data_in      = wr_data;
            if (wr_valid) begin
               addr_d = addr_q + addr_size'(1);
               cnt_d  = cnt_q + (len_size+1)'(1);
               if (cnt_q == {1'b0, len_q}) begin
                  state_d = IDLE;
               end
            end
         end
         READ: begin
            if ((cnt_q != beats) && (occ < 3'd2)) begin
               rd_en      = 1'b1;
               rd_adress  = addr_q;
               addr_d     = addr_q + addr_size'(1);
               cnt_d      = cnt_q + (len_size+1)'(1);
               inflight_d = 1'b1;
            end
            // Leave only once the final beat has been handed to the consumer.
            if ((cnt_q == beats) && !inflight_q &&
                ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         ret_q      <= '0;
         inflight_q <= 1'b0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         ret_q      <= ret_d;
         inflight_q <= inflight_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Buffer entries are reset so rd_data/rd_last read as zero out of reset.
   for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            fifo_data_q[gi] <= '0;
            fifo_last_q[gi] <= 1'b0;
         end else begin
            fifo_data_q[gi] <= fifo_data_d[gi];
            fifo_last_q[gi] <= fifo_last_d[gi];
         end
      end
   end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_burst_ctrl
//    Directed bench for mem_burst_ctrl. A behavioural RAM sits on the RAM
//    ports; an expected-memory image plus queues of expected write beats and
//    load beats form the reference, checked by one compare process on every
//    falling edge. Literal expectations pin the reference for key bursts.
// ----------------------------------------------------------------------------
module tb_mem_burst_ctrl;

   logic       clk, rst;
   logic       req_valid, req_ready, req_write;
   logic [7:0] req_addr;
   logic [3:0] req_len;
   logic [7:0] wr_data;
   logic       wr_valid, wr_ready;
   logic [7:0] rd_data;
   logic       rd_valid, rd_last, rd_ready, busy;
   logic       write_en, rd_en;
   logic [7:0] write_adress, data_in, rd_adress;
   logic [7:0] data_out;

   mem_burst_ctrl #(.addr_size(8), .data_size(8), .len_size(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
      .rd_ready(rd_ready), .busy(busy),
      .write_en(write_en), .write_adress(write_adress), .data_in(data_in),
      .rd_en(rd_en), .rd_adress(rd_adress), .data_out(data_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Behavioural RAM and the expected image of its contents.
   logic [7:0] ram    [256];
   logic [7:0] shadow [256];
   initial begin
      data_out = 8'h00;
      for (int i = 0; i < 256; i++) begin
         ram[i]    = 8'(i) ^ 8'h5A;
         shadow[i] = 8'(i) ^ 8'h5A;
      end
   end
   always @(posedge clk) begin
      if (write_en) ram[write_adress] <= data_in;
      if (rd_en)    data_out <= ram[rd_adress];
   end

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct packed { logic [7:0] a; logic [7:0] d; } wbeat_t;
   typedef struct packed { logic [7:0] d; logic l; } rbeat_t;
   wbeat_t     wq[$];
   rbeat_t     rq[$];
   logic [7:0] wlog_addr[$];
   int         wlog_cyc[$];
   logic [7:0] plog_d[$];
   logic       plog_l[$];
   int         outstanding     = 0;
   int         accept_cyc      = 0;
   int         first_wen_cyc   = -1;
   int         first_rden_cyc  = -1;
   int         first_valid_cyc = -1;
   logic       prev_stall      = 1'b0;
   logic [7:0] prev_d          = 8'h00;
   logic       prev_l          = 1'b0;

   // Compare process: outputs sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         outstanding = 0;
         prev_stall  = 1'b0;
      end else begin
         chk("en_exclusive", 32'(rd_en & write_en), 32'd0);
         if (!busy) chk("idle_enables", 32'({rd_en, write_en}), 32'd0);
         if (prev_stall) begin
            chk("stall_valid", 32'(rd_valid), 32'd1);
            chk("stall_data",  32'(rd_data),  32'(prev_d));
            chk("stall_last",  32'(rd_last),  32'(prev_l));
         end
         if (write_en) begin
            if (first_wen_cyc < 0) first_wen_cyc = cyc;
            wlog_addr.push_back(write_adress);
            wlog_cyc.push_back(cyc);
            chk("wq_nonempty", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
               wbeat_t w;
               w = wq.pop_front();
               chk("wr_addr", 32'(write_adress), 32'(w.a));
               chk("wr_data", 32'(data_in), 32'(w.d));
            end
         end
         if (rd_en) begin
            outstanding = outstanding + 1;
            if (first_rden_cyc < 0) first_rden_cyc = cyc;
         end
         if (rd_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (rd_valid && rd_ready) begin
            outstanding = outstanding - 1;
            plog_d.push_back(rd_data);
            plog_l.push_back(rd_last);
            chk("rq_nonempty", 32'(rq.size() != 0), 32'd1);
            if (rq.size() != 0) begin
               rbeat_t r;
               r = rq.pop_front();
               chk("rd_data", 32'(rd_data), 32'(r.d));
               chk("rd_last", 32'(rd_last), 32'(r.l));
            end
         end
         if (rd_en) chk("credit", 32'(outstanding <= 2), 32'd1);
         prev_stall = rd_valid && !rd_ready;
         prev_d     = rd_data;
         prev_l     = rd_last;
      end
   end

   // rd_ready driver: held high (mode 0) or a fixed toggling pattern (mode 1).
   int          rd_mode = 0;
   int          pidx    = 0;
   logic [15:0] pat     = 16'b1011_0010_0110_1001;
   initial begin
      rd_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rd_mode == 0) rd_ready = 1'b1;
         else begin
            rd_ready = pat[pidx % 16];
            pidx     = pidx + 1;
         end
      end
   end

   logic [7:0] wdata [16];

   task automatic wait_idle();
      int g = 0;
      while (busy && g < 300) begin
         @(posedge clk); #1;
         g++;
      end
      chk("idle_reached", 32'(busy), 32'd0);
   endtask

   task automatic issue_req(input logic wr, input logic [7:0] a, input logic [3:0] len);
      int g = 0;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_len   = len;
      while (!req_ready && g < 50) begin
         @(posedge clk); #1;
         g++;
      end
      chk("req_ready_seen", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      accept_cyc = cyc;
      req_valid  = 1'b0;
   endtask

   task automatic do_store(input logic [7:0] a, input logic [3:0] len, input int gap);
      int   b = 0;
      int   g = 0;
      logic hand;
      $display("store addr=0x%02h len=%0d gap=%0d", a, len, gap);
      for (int i = 0; i <= int'(len); i++) begin
         logic [7:0] aa;
         aa = a + 8'(i);
         wq.push_back('{aa, wdata[i]});
         shadow[aa] = wdata[i];
      end
      wlog_addr.delete();
      wlog_cyc.delete();
      first_wen_cyc = -1;
      issue_req(1'b1, a, len);
      while (b <= int'(len) && g < 200) begin
         wr_valid = (gap == 0) || (g % 3 != 1);
         wr_data  = wdata[b];
         hand     = wr_valid && wr_ready;
         @(posedge clk); #1;
         if (hand) b++;
         g++;
      end
      wr_valid = 1'b0;
      chk("store_beats", 32'(b), 32'(int'(len) + 1));
      wait_idle();
      chk("wq_drained", 32'(wq.size()), 32'd0);
   endtask

   task automatic expect_load(input logic [7:0] a, input logic [3:0] len);
      for (int i = 0; i <= int'(len); i++) begin
         logic [7:0] aa;
         aa = a + 8'(i);
         rq.push_back('{shadow[aa], (i == int'(len))});
      end
      plog_d.delete();
      plog_l.delete();
      first_rden_cyc  = -1;
      first_valid_cyc = -1;
   endtask

   task automatic do_load(input logic [7:0] a, input logic [3:0] len, input int mode);
      $display("load  addr=0x%02h len=%0d mode=%0d", a, len, mode);
      expect_load(a, len);
      rd_mode = mode;
      issue_req(1'b0, a, len);
      wait_idle();
      rd_mode = 0;
      chk("rq_drained", 32'(rq.size()), 32'd0);
      chk("load_beats", 32'(plog_d.size()), 32'(int'(len) + 1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 8'h00;
      req_len   = 4'h0;
      wr_data   = 8'h00;
      wr_valid  = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_rd_valid",  32'(rd_valid),  32'd0);
      chk("rst_rd_en",     32'(rd_en),     32'd0);
      chk("rst_write_en",  32'(write_en),  32'd0);
      chk("rst_wr_ready",  32'(wr_ready),  32'd0);
      #10 rst = 1'b1;
      @(posedge clk); #1;

      // Store 0x10..0x13, valid held high.
      wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33; wdata[3] = 8'h44;
      do_store(8'h10, 4'd3, 0);
      chk("t1_first_wen_delay", 32'(first_wen_cyc - accept_cyc), 32'd0);
      chk("t1_wcount", 32'(wlog_addr.size()), 32'd4);
      if (wlog_addr.size() == 4) begin
         chk("t1_waddr0", 32'(wlog_addr[0]), 32'h10);
         chk("t1_waddr3", 32'(wlog_addr[3]), 32'h13);
         for (int i = 1; i < 4; i++)
            chk("t1_wr_consecutive", 32'(wlog_cyc[i] - wlog_cyc[0]), 32'(i));
      end
      do_load(8'h10, 4'd3, 0);
      if (plog_d.size() == 4) begin
         chk("t1_rd0",   32'(plog_d[0]), 32'h11);
         chk("t1_rd3",   32'(plog_d[3]), 32'h44);
         chk("t1_last2", 32'(plog_l[2]), 32'd0);
         chk("t1_last3", 32'(plog_l[3]), 32'd1);
      end

      // Store across the address wrap.
      wdata[0] = 8'hA1; wdata[1] = 8'hB2; wdata[2] = 8'hC3;
      do_store(8'hFE, 4'd2, 0);
      if (wlog_addr.size() == 3) begin
         chk("wrap_waddr0", 32'(wlog_addr[0]), 32'hFE);
         chk("wrap_waddr1", 32'(wlog_addr[1]), 32'hFF);
         chk("wrap_waddr2", 32'(wlog_addr[2]), 32'h00);
      end
      do_load(8'hFE, 4'd2, 0);
      if (plog_d.size() == 3) begin
         chk("wrap_rd0", 32'(plog_d[0]), 32'hA1);
         chk("wrap_rd2", 32'(plog_d[2]), 32'hC3);
      end

      // 8-beat load from the initial image with consumer stalls.
      do_load(8'h40, 4'd7, 1);
      if (plog_d.size() == 8) begin
         chk("stall_rd0", 32'(plog_d[0]), 32'h1A);
         chk("stall_rd7", 32'(plog_d[7]), 32'h1D);
      end

      // Store with wr_valid gaps, read back with stalls.
      for (int i = 0; i < 5; i++) wdata[i] = 8'hC0 + 8'(i * 7);
      do_store(8'h80, 4'd4, 1);
      do_load(8'h80, 4'd4, 1);

      // Single-beat store then load; latency check.
      wdata[0] = 8'h3C;
      do_store(8'hA5, 4'd0, 0);
      do_load(8'hA5, 4'd0, 0);
      chk("single_rden_delay",  32'(first_rden_cyc - accept_cyc),  32'd0);
      // rd_valid appears in the third cycle after the accepting edge.
      chk("single_valid_delay", 32'(first_valid_cyc - accept_cyc), 32'd2);
      if (plog_d.size() == 1) begin
         chk("single_data", 32'(plog_d[0]), 32'h3C);
         chk("single_last", 32'(plog_l[0]), 32'd1);
      end

      // Reset in the middle of an 8-beat load.
      begin
         int g = 0;
         $display("load  addr=0x60 len=7 reset mid-burst");
         expect_load(8'h60, 4'd7);
         issue_req(1'b0, 8'h60, 4'd7);
         while (plog_d.size() < 2 && g < 50) begin
            @(posedge clk); #1;
            g++;
         end
         chk("mid_beats_before_rst", 32'(plog_d.size()), 32'd2);
         #1 rst = 1'b0;
         #1;
         chk("mrst_rd_valid",  32'(rd_valid),     32'd0);
         chk("mrst_rd_en",     32'(rd_en),        32'd0);
         chk("mrst_rd_last",   32'(rd_last),      32'd0);
         chk("mrst_rd_data",   32'(rd_data),      32'd0);
         chk("mrst_busy",      32'(busy),         32'd0);
         chk("mrst_req_ready", 32'(req_ready),    32'd1);
         chk("mrst_rd_adress", 32'(rd_adress),    32'd0);
         chk("mrst_wr_adress", 32'(write_adress), 32'd0);
         rq.delete();
         @(posedge clk);
         @(posedge clk);
         #2 rst = 1'b1;
         #1;
         chk("post_rst_rd_valid", 32'(rd_valid), 32'd0);
         chk("post_rst_busy",     32'(busy),     32'd0);
         @(posedge clk); #1;
         do_load(8'h60, 4'd7, 1);
         if (plog_d.size() == 8) begin
            chk("after_rst_rd0", 32'(plog_d[0]), 32'h3A);
            chk("after_rst_rd7", 32'(plog_d[7]), 32'h3D);
         end
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
